// File: rtl/rom_load_sequencer_pkg.sv
// rom_load_sequencer_pkg
//   Shared definitions for the cartridge load sequencer: word packing
//   geometry, colour codes, sequencer state encoding and the checksum step
//   used when ROM_CHECKSUM_EN is defined.
package rom_load_sequencer_pkg;

  localparam int NIBS_PER_WORD = 6;
  localparam int DATA_W        = 2 * NIBS_PER_WORD;
  localparam int NIB_CNT_W     = $clog2(NIBS_PER_WORD);

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    BLUE   = 2'b10,
    YELLOW = 2'b11
  } color_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_NIB,
    S_TRIGGER,
    S_WAIT_DET,
    S_PACK,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  // Folds one written word into the running 8-bit checksum: low byte plus
  // the upper nibble, modulo 256.
  function automatic logic [7:0] checksumStep(input logic [7:0] sum,
                                              input logic [DATA_W-1:0] word);
    return sum + word[7:0] + {4'h0, word[11:8]};
  endfunction

endpackage

// File: rtl/rom_load_sequencer_nib_packer.sv
// nib_packer
//   Shift register that collects 2-bit colours into a DATA_W word, first
//   colour ending up in the top bits, plus the count of nibs in the word.
//   A flush left-aligns a partial word and zero fills the unused low nibs.
// Ports
//   i_clk, i_rst   clock, async active-high reset
//   i_clear        empty the word and nib count (new load)
//   i_shift        shift i_color into the bottom of the word
//   i_color        colour code being shifted in
//   i_advance      count the nib just shifted (wraps after a full word)
//   i_flush        left-align the partial word, reset nib count
//   o_word         packed word
//   o_nibCnt       nibs already counted in the current word
//   o_wordFull     the nib being counted completes the word
module nib_packer
  import rom_load_sequencer_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_shift,
  input  logic [1:0]           i_color,
  input  logic                 i_advance,
  input  logic                 i_flush,
  output logic [DATA_W-1:0]    o_word,
  output logic [NIB_CNT_W-1:0] o_nibCnt,
  output logic                 o_wordFull
);

  localparam int SHIFT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]    r_word;
  logic [NIB_CNT_W-1:0] r_nibCnt;
  logic [SHIFT_W-1:0]   w_flushShift;

  // Stale bits from the previous word sit above the fresh nibs; shifting by
  // the number of missing nibs pushes them out and zero fills the bottom.
  assign w_flushShift = SHIFT_W'(2 * (NIBS_PER_WORD - int'(r_nibCnt)));
  assign o_wordFull   = (r_nibCnt == NIB_CNT_W'(NIBS_PER_WORD - 1));
  assign o_word       = r_word;
  assign o_nibCnt     = r_nibCnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word   <= '0;
      r_nibCnt <= '0;
    end else if (i_clear) begin
      r_word   <= '0;
      r_nibCnt <= '0;
    end else if (i_shift) begin
      r_word <= {r_word[DATA_W-3:0], i_color};
    end else if (i_flush) begin
      r_word   <= r_word << w_flushShift;
      r_nibCnt <= '0;
    end else if (i_advance) begin
      r_nibCnt <= o_wordFull ? '0 : r_nibCnt + NIB_CNT_W'(1);
    end
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Sequences one cartridge read: waits for nib-centre pulses, triggers one
//   colour detection per nib, packs colours six per word and writes the
//   words to program RAM, holding the CPU in reset until the load is done.
//   Optional feature macro: ROM_CHECKSUM_EN (running 8-bit checksum of
//   written words; tied to zero when undefined).
// Ports
//   i_clk, i_rst      1 MHz clock, async active-high reset
//   i_start           load request, honoured only in IDLE/DONE/ERROR
//   i_nibCenter       nib-centre pulse from the motion controller
//   i_rowDone         traverse finished (level)
//   o_detStart        one-cycle colour detection request
//   i_detDone         detection result valid, i_detColor holds the colour
//   o_ramWe           one-cycle RAM write strobe
//   o_ramWaddr        RAM write address
//   o_ramWdata        packed word, first nib in the top bits
//   o_cpuHold         CPU held in reset
//   o_busy/o_done/o_error  load in progress / completed / aborted
//   o_wordsWritten    completed writes
//   o_checksum        running checksum
module rom_load_sequencer
  import rom_load_sequencer_pkg::*;
#(
  parameter int WORDS_TOTAL = 60,
  parameter int ADDR_W      = 8,
  parameter int DET_TIMEOUT = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_nibCenter,
  input  logic              i_rowDone,
  output logic              o_detStart,
  input  logic              i_detDone,
  input  logic [1:0]        i_detColor,
  output logic              o_ramWe,
  output logic [ADDR_W-1:0] o_ramWaddr,
  output logic [DATA_W-1:0] o_ramWdata,
  output logic              o_cpuHold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_wordsWritten,
  output logic [7:0]        o_checksum
);

  localparam int TMO_W = $clog2(DET_TIMEOUT + 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [ADDR_W-1:0]    r_wordCnt;
  logic                 r_lastWrite;
  logic [TMO_W-1:0]     r_tmo;
  logic                 w_accept;
  logic                 w_shift;
  logic                 w_advance;
  logic                 w_flush;
  logic [DATA_W-1:0]    w_word;
  logic [NIB_CNT_W-1:0] w_nibCnt;
  logic                 w_wordFull;

  nib_packer u_packer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_accept),
    .i_shift    (w_shift),
    .i_color    (i_detColor),
    .i_advance  (w_advance),
    .i_flush    (w_flush),
    .o_word     (w_word),
    .o_nibCnt   (w_nibCnt),
    .o_wordFull (w_wordFull)
  );

  // Next state and strobes. Overrun (nib_center while a detection is still
  // outstanding) takes priority over a detection completing. The timeout
  // fires when the cycle now ending would be the DET_TIMEOUT-th in WAIT_DET.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_advance   = 1'b0;
    w_flush     = 1'b0;
    o_detStart  = 1'b0;
    o_ramWe     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_nextState = S_WAIT_NIB;
        end
      end
      S_WAIT_NIB: begin
        if (i_nibCenter) begin
          w_nextState = S_TRIGGER;
        end else if (i_rowDone) begin
          if (w_nibCnt != '0) begin
            w_flush     = 1'b1;
            w_nextState = S_WRITE;
          end else begin
            w_nextState = S_DONE;
          end
        end
      end
      S_TRIGGER: begin
        o_detStart  = 1'b1;
        w_nextState = i_nibCenter ? S_ERROR : S_WAIT_DET;
      end
      S_WAIT_DET: begin
        if (i_nibCenter) begin
          w_nextState = S_ERROR;
        end else if (i_detDone) begin
          w_shift     = 1'b1;
          w_nextState = S_PACK;
        end else if (r_tmo == TMO_W'(DET_TIMEOUT - 1)) begin
          w_nextState = S_ERROR;
        end
      end
      S_PACK: begin
        w_advance   = 1'b1;
        w_nextState = w_wordFull ? S_WRITE : S_WAIT_NIB;
      end
      S_WRITE: begin
        o_ramWe = 1'b1;
        if (r_lastWrite || (r_wordCnt == ADDR_W'(WORDS_TOTAL - 1))) begin
          w_nextState = S_DONE;
        end else begin
          w_nextState = S_WAIT_NIB;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register, word counter (also the write address), the flag that
  // makes a flushed partial word the final write, and the detection timer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_wordCnt   <= '0;
      r_lastWrite <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_wordCnt   <= '0;
        r_lastWrite <= 1'b0;
      end else if (r_state == S_WRITE) begin
        r_wordCnt <= r_wordCnt + ADDR_W'(1);
      end
      if (w_flush) begin
        r_lastWrite <= 1'b1;
      end
      if (r_state == S_TRIGGER) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT_DET) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [7:0] r_checksum;

  // Accumulates every word as it is strobed into RAM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_checksum <= 8'h00;
    end else if (w_accept) begin
      r_checksum <= 8'h00;
    end else if (r_state == S_WRITE) begin
      r_checksum <= checksumStep(r_checksum, w_word);
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = 8'h00;
`endif

  assign o_ramWaddr     = r_wordCnt;
  assign o_ramWdata     = w_word;
  assign o_wordsWritten = r_wordCnt;
  assign o_done         = (r_state == S_DONE);
  assign o_error        = (r_state == S_ERROR);
  assign o_cpuHold      = (r_state != S_DONE);
  assign o_busy         = !((r_state == S_IDLE) || (r_state == S_DONE) ||
                            (r_state == S_ERROR));

endmodule

// File: tb/tb_rom_load_sequencer.sv
`timescale 1ns/1ps
module tb_rom_load_sequencer;

  localparam int WORDS = 3;
  localparam int TMO   = 10;
  localparam int AW    = 8;

  logic          clk, rst, start, nibCenter, rowDone, detDone;
  logic [1:0]    detColor;
  logic          detStart, ramWe, cpuHold, busy, done, error;
  logic [AW-1:0] ramWaddr, wordsWritten;
  logic [11:0]   ramWdata;
  logic [7:0]    checksum;

  int total = 0;
  int bad   = 0;

  logic [1:0]  cols [0:17];
  logic [19:0] gotQ [$];

  rom_load_sequencer #(.WORDS_TOTAL(WORDS), .ADDR_W(AW), .DET_TIMEOUT(TMO)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_nibCenter    (nibCenter),
    .i_rowDone      (rowDone),
    .o_detStart     (detStart),
    .i_detDone      (detDone),
    .i_detColor     (detColor),
    .o_ramWe        (ramWe),
    .o_ramWaddr     (ramWaddr),
    .o_ramWdata     (ramWdata),
    .o_cpuHold      (cpuHold),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_wordsWritten (wordsWritten),
    .o_checksum     (checksum)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  // Every RAM strobe is logged as {addr, data}.
  always @(negedge clk) begin
    if (ramWe === 1'b1) gotQ.push_back({ramWaddr, ramWdata});
  end

  task automatic applyReset();
    rst = 1'b1; start = 1'b0; nibCenter = 1'b0; rowDone = 1'b0;
    detDone = 1'b0; detColor = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one load of nNibs colours from cols[], finishing with row_done when
  // the cartridge is not full. Optionally injects ignored start/det_done.
  task automatic applyStimulus(input int nNibs, input bit spurious, output bit timedOut);
    bit seen;
    timedOut = 1'b0;
    gotQ.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < nNibs; i++) begin
      if (spurious) begin
        @(negedge clk); start = 1'b1; detDone = 1'b1; detColor = 2'($urandom_range(0, 3));
        @(negedge clk); start = 1'b0; detDone = 1'b0;
      end
      @(negedge clk); nibCenter = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk); nibCenter = 1'b0;
        if (detStart === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
        timedOut = 1'b1;
        return;
      end
      repeat ($urandom_range(0, 5) + 1) @(negedge clk);
      detDone = 1'b1; detColor = cols[i];
      @(negedge clk); detDone = 1'b0;
      repeat (3) @(negedge clk);
    end
    if (nNibs < 6 * WORDS) rowDone = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    rowDone = 1'b0;
    if (!seen) timedOut = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    applyReset();
    total++; if (cpuHold !== 1'b1) begin bad++; $display("[TB] FAIL reset_cpuHold: got %0b expected 1", cpuHold); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %0b expected 0", error); end
    total++; if (ramWe !== 1'b0 || detStart !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes: got we=%0b det=%0b expected 0", ramWe, detStart); end
    total++; if (wordsWritten !== '0 || ramWaddr !== '0) begin bad++; $display("[TB] FAIL reset_counts: got %0h/%0h expected 0", wordsWritten, ramWaddr); end
    total++; if (checksum !== 8'h00) begin bad++; $display("[TB] FAIL reset_checksum: got %0h expected 0", checksum); end
  endtask

  task automatic test_single_word();
    bit tmo;
    cols[0] = 2'd0; cols[1] = 2'd1; cols[2] = 2'd2; cols[3] = 2'd3; cols[4] = 2'd0; cols[5] = 2'd1;
    applyStimulus(6, 1'b1, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL single_timeout: got %0b expected 0", tmo); end
    total++;
    if (gotQ.size() != 1) begin bad++; $display("[TB] FAIL single_count: got %0d expected 1", gotQ.size()); end
    else if (gotQ[0] !== {8'd0, 12'h1B1}) begin bad++; $display("[TB] FAIL single_word: got %0h expected %0h", gotQ[0], {8'd0, 12'h1B1}); end
    total++; if (done !== 1'b1 || cpuHold !== 1'b0) begin bad++; $display("[TB] FAIL single_done: got done=%0b hold=%0b expected 1/0", done, cpuHold); end
    total++; if (wordsWritten !== 8'd1) begin bad++; $display("[TB] FAIL single_words: got %0d expected 1", wordsWritten); end
  endtask

  task automatic test_full();
    bit tmo;
    for (int i = 0; i < 18; i++) cols[i] = 2'd3;
    applyStimulus(18, 1'b0, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL full_timeout: got %0b expected 0", tmo); end
    total++; if (gotQ.size() != 3) begin bad++; $display("[TB] FAIL full_count: got %0d expected 3", gotQ.size()); end
    for (int w = 0; w < gotQ.size() && w < 3; w++) begin
      total++;
      if (gotQ[w] !== {8'(w), 12'hFFF}) begin bad++; $display("[TB] FAIL full_word%0d: got %0h expected %0h", w, gotQ[w], {8'(w), 12'hFFF}); end
    end
    total++; if (done !== 1'b1 || cpuHold !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL full_done: got done=%0b hold=%0b busy=%0b expected 1/0/0", done, cpuHold, busy); end
    total++; if (wordsWritten !== 8'd3) begin bad++; $display("[TB] FAIL full_words: got %0d expected 3", wordsWritten); end
  endtask

  task automatic test_partial();
    bit tmo;
    cols[0] = 2'd1; cols[1] = 2'd2; cols[2] = 2'd3;
    applyStimulus(3, 1'b0, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL partial_timeout: got %0b expected 0", tmo); end
    total++;
    if (gotQ.size() != 1) begin bad++; $display("[TB] FAIL partial_count: got %0d expected 1", gotQ.size()); end
    else if (gotQ[0] !== {8'd0, 12'h6C0}) begin bad++; $display("[TB] FAIL partial_word: got %0h expected %0h", gotQ[0], {8'd0, 12'h6C0}); end
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL partial_done: got %0b expected 1", done); end
  endtask

  // Random loads back to back, each compared with a word-level model:
  // word w holds colours 6w..6w+5, first in the top bits, missing ones 0.
  task automatic test_back_to_back();
    bit tmo;
    int nNibs, nW;
    logic [11:0] d;
    logic [7:0] expSum;
    logic [19:0] expQ [$];
    for (int run = 0; run < 6; run++) begin
      nNibs = $urandom_range(1, 18);
      for (int i = 0; i < 18; i++) cols[i] = 2'($urandom_range(0, 3));
      applyStimulus(nNibs, 1'($urandom_range(0, 1)), tmo);
      expQ.delete();
      expSum = 8'h00;
      nW = (nNibs + 5) / 6;
      for (int w = 0; w < nW; w++) begin
        d = 12'h000;
        for (int k = 0; k < 6; k++) begin
          if (6 * w + k < nNibs) d = d | (12'(cols[6 * w + k]) << (10 - 2 * k));
        end
        expQ.push_back({8'(w), d});
`ifdef ROM_CHECKSUM_EN
        expSum = expSum + d[7:0] + {4'h0, d[11:8]};
`endif
      end
      total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL b2b%0d_timeout: got %0b expected 0", run, tmo); end
      total++; if (gotQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL b2b%0d_count: got %0d expected %0d", run, gotQ.size(), expQ.size()); end
      for (int w = 0; w < gotQ.size() && w < expQ.size(); w++) begin
        total++;
        if (gotQ[w] !== expQ[w]) begin bad++; $display("[TB] FAIL b2b%0d_word%0d: got %0h expected %0h", run, w, gotQ[w], expQ[w]); end
      end
      total++; if (wordsWritten !== 8'(nW)) begin bad++; $display("[TB] FAIL b2b%0d_words: got %0d expected %0d", run, wordsWritten, nW); end
      total++; if (done !== 1'b1 || cpuHold !== 1'b0) begin bad++; $display("[TB] FAIL b2b%0d_done: got done=%0b hold=%0b expected 1/0", run, done, cpuHold); end
      total++; if (checksum !== expSum) begin bad++; $display("[TB] FAIL b2b%0d_checksum: got %0h expected %0h", run, checksum, expSum); end
    end
  endtask

  // Starts a load and stops once the detector has been triggered.
  task automatic startAndTrigger(output bit seen);
    gotQ.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); nibCenter = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk); nibCenter = 1'b0;
      if (detStart === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_timeout();
    bit seen;
    startAndTrigger(seen);
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL tmo_trigger: got %0b expected 1", seen); end
    repeat (10) @(negedge clk);
    total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL tmo_early: got %0b expected 0", error); end
    @(negedge clk);
    total++; if (error !== 1'b1 || cpuHold !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL tmo_error: got err=%0b hold=%0b busy=%0b expected 1/1/0", error, cpuHold, busy); end
    total++; if (gotQ.size() != 0) begin bad++; $display("[TB] FAIL tmo_writes: got %0d expected 0", gotQ.size()); end
  endtask

  task automatic test_overrun();
    bit seen;
    startAndTrigger(seen);
    total++; if (error !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL ovr_restart: got err=%0b busy=%0b expected 0/1", error, busy); end
    @(negedge clk); nibCenter = 1'b1;
    @(negedge clk); nibCenter = 1'b0;
    total++; if (error !== 1'b1) begin bad++; $display("[TB] FAIL ovr_error: got %0b expected 1", error); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (error !== 1'b0 || busy !== 1'b1 || cpuHold !== 1'b1) begin bad++; $display("[TB] FAIL ovr_clear: got err=%0b busy=%0b hold=%0b expected 0/1/1", error, busy, cpuHold); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    applyReset();
    startAndTrigger(seen);
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL rmid_trigger: got %0b expected 1", seen); end
    @(negedge clk);
    #100 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || cpuHold !== 1'b1 || detStart !== 1'b0) begin bad++; $display("[TB] FAIL rmid_async: got busy=%0b hold=%0b det=%0b expected 0/1/0", busy, cpuHold, detStart); end
    total++; if (error !== 1'b0 || done !== 1'b0 || wordsWritten !== '0) begin bad++; $display("[TB] FAIL rmid_flags: got err=%0b done=%0b words=%0d expected 0", error, done, wordsWritten); end
    @(negedge clk); detDone = 1'b1;
    @(negedge clk); detDone = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (gotQ.size() != 0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_quiet: got writes=%0d busy=%0b expected 0/0", gotQ.size(), busy); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full();
    test_partial();
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
